// File: rtl/frontend.sv
`default_nettype none
// ==============================================================================
// frontend : RV32I fetch/decode/control stage (PC, IR, GPR file, branch resolve)
// Optional macro FRONTEND_HALT_ON_ILLEGAL_EN halts on illegal encodings. Rev 1.0
// ==============================================================================
module frontend #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  output logic [7:0]  o_alu_op,
  output logic [7:0]  o_mem_op,
  output logic        o_load,
  output logic        o_store,
  output logic [31:0] o_alu_opr_1,
  output logic [31:0] o_alu_opr_2,
  output logic [31:0] o_rs2_data,
  input  logic [31:0] i_gpr_di,
  input  logic        i_is_lt,
  input  logic        i_is_ltu,
  input  logic        i_is_zero,
  output logic        o_halt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_misc   = 7'b0001111;
  localparam logic [6:0] c_op_system = 7'b1110011;

  localparam logic [7:0] c_alu_add  = 8'hFB;
  localparam logic [7:0] c_alu_sub  = 8'hFA;
  localparam logic [7:0] c_alu_slt  = 8'h7A;
  localparam logic [7:0] c_alu_sltu = 8'hBA;
  localparam logic [7:0] c_alu_sll  = 8'hDB;
  localparam logic [7:0] c_alu_srl  = 8'hEB;
  localparam logic [7:0] c_alu_sra  = 8'hF3;
  localparam logic [7:0] c_alu_xor  = 8'hFC;
  localparam logic [7:0] c_alu_or   = 8'hFD;
  localparam logic [7:0] c_alu_and  = 8'hFE;

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, w_next_pc;
  logic [31:0] r_ir;
  logic [31:0] r_gpr [32];
  logic        w_we;

  logic [6:0]  w_opcode, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic [31:0] w_pc_plus4, w_pc_target, w_jalr_target;
  logic [7:0]  w_alu_code;
  logic        w_legal, w_taken, w_jump;
  logic [31:0] w_target;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_gpr[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_gpr[w_rs2];

  // One shared PC-relative adder serves both JAL and taken branches
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_pc_target   = r_pc + ((w_opcode == c_op_jal) ? w_imm_j : w_imm_b);
  assign w_jalr_target = (w_rs1_val + w_imm_i) & 32'hFFFF_FFFE;

  assign o_imem_addr = r_pc;
  assign o_halt      = (r_state == S_HALT);

  always_comb begin
    w_alu_code = c_alu_add;
    case (w_f3)
      3'b000: w_alu_code = (w_opcode == c_op_op && w_f7[5]) ? c_alu_sub : c_alu_add;
      3'b001: w_alu_code = c_alu_sll;
      3'b010: w_alu_code = c_alu_slt;
      3'b011: w_alu_code = c_alu_sltu;
      3'b100: w_alu_code = c_alu_xor;
      3'b101: w_alu_code = w_f7[5] ? c_alu_sra : c_alu_srl;
      3'b110: w_alu_code = c_alu_or;
      default: w_alu_code = c_alu_and;
    endcase
  end

  always_comb begin
    w_legal = 1'b1;
    case (w_opcode)
      c_op_op:     w_legal = (w_f7 == 7'b0000000) ||
                             (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
      c_op_imm: begin
        if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'b0000000);
        else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
      end
      c_op_lui, c_op_auipc, c_op_jal: w_legal = 1'b1;
      c_op_jalr:   w_legal = (w_f3 == 3'b000);
      c_op_branch: w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
      c_op_load:   w_legal = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      c_op_store:  w_legal = w_f3 inside {3'b000, 3'b001, 3'b010};
      c_op_misc:   w_legal = (w_f3 == 3'b000);
      c_op_system: w_legal = (w_f3 == 3'b000);
      default:     w_legal = 1'b0;
    endcase
  end

  // Backend flags are active-low: a flag reading 0 means the relation holds
  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = !i_is_zero;
      3'b001:  w_taken = i_is_zero;
      3'b100:  w_taken = !i_is_lt;
      3'b101:  w_taken = i_is_lt;
      3'b110:  w_taken = !i_is_ltu;
      3'b111:  w_taken = i_is_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    o_alu_op     = c_alu_add;
    o_mem_op     = 8'hFF;
    o_load       = 1'b1;
    o_store      = 1'b1;
    o_alu_opr_1  = 32'd0;
    o_alu_opr_2  = 32'd0;
    o_rs2_data   = 32'd0;
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_we         = 1'b0;
    w_jump       = 1'b0;
    w_target     = w_pc_target;
    case (r_state)
      S_FETCH: w_next_state = S_FETCH == r_state ? S_EXEC : S_FETCH;
      S_EXEC: begin
        w_next_state = S_FETCH;
        w_next_pc    = w_pc_plus4;
        o_rs2_data   = w_rs2_val;
        if (!w_legal) begin
`ifdef FRONTEND_HALT_ON_ILLEGAL_EN
          w_next_state = S_HALT;
          w_next_pc    = r_pc;
`endif
        end else begin
          case (w_opcode)
            c_op_op: begin
              o_alu_opr_1 = w_rs1_val;
              o_alu_opr_2 = w_rs2_val;
              o_alu_op    = w_alu_code;
              w_we        = 1'b1;
            end
            c_op_imm: begin
              o_alu_opr_1 = w_rs1_val;
              o_alu_opr_2 = (w_f3 == 3'b001 || w_f3 == 3'b101) ? {27'd0, w_imm_i[4:0]} : w_imm_i;
              o_alu_op    = w_alu_code;
              w_we        = 1'b1;
            end
            c_op_lui: begin
              o_alu_opr_2 = w_imm_u;
              w_we        = 1'b1;
            end
            c_op_auipc: begin
              o_alu_opr_1 = r_pc;
              o_alu_opr_2 = w_imm_u;
              w_we        = 1'b1;
            end
            c_op_jal, c_op_jalr: begin
              o_alu_opr_1 = r_pc;
              o_alu_opr_2 = 32'd4;
              w_we        = 1'b1;
              w_jump      = 1'b1;
              w_target    = (w_opcode == c_op_jalr) ? w_jalr_target : w_pc_target;
            end
            c_op_branch: begin
              o_alu_opr_1 = w_rs1_val;
              o_alu_opr_2 = w_rs2_val;
              o_alu_op    = c_alu_sub;
              w_jump      = w_taken;
            end
            c_op_load: begin
              o_alu_opr_1 = w_rs1_val;
              o_alu_opr_2 = w_imm_i;
              o_load      = 1'b0;
              w_we        = 1'b1;
              case (w_f3)
                3'b000:  o_mem_op = 8'h7F;
                3'b001:  o_mem_op = 8'hBF;
                3'b010:  o_mem_op = 8'hDF;
                3'b100:  o_mem_op = 8'hEF;
                default: o_mem_op = 8'hF7;
              endcase
            end
            c_op_store: begin
              o_alu_opr_1 = w_rs1_val;
              o_alu_opr_2 = w_imm_s;
              o_store     = 1'b0;
              o_mem_op    = ~(8'h04 >> w_f3);
            end
            c_op_system: begin
              w_next_state = S_HALT;
              w_next_pc    = r_pc;
            end
            default: ;
          endcase
          if (w_jump) begin
            if (w_target[1]) begin
              w_next_state = S_HALT;
              w_next_pc    = r_pc;
              w_we         = 1'b0;
            end else begin
              w_next_pc = w_target;
            end
          end
        end
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
    if (w_rd == 5'd0) w_we = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 32'h0000_0013;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (r_state == S_FETCH) r_ir <= i_imem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= 32'd0;
    end else if (w_we) begin
      r_gpr[w_rd] <= i_gpr_di;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frontend.sv
`default_nettype none
// tb_frontend: scoreboard checks of the frontend stage; the bench plays the
// instruction ROM and the backend (gpr_di and flags) for each instruction.
module tb_frontend;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] o_imem_addr, i_imem_data, o_alu_opr_1, o_alu_opr_2, o_rs2_data, i_gpr_di;
  logic [7:0]  o_alu_op, o_mem_op;
  logic        o_load, o_store, o_halt;
  logic        i_is_lt, i_is_ltu, i_is_zero;

  frontend #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_addr(o_imem_addr), .i_imem_data(i_imem_data),
    .o_alu_op(o_alu_op), .o_mem_op(o_mem_op), .o_load(o_load), .o_store(o_store),
    .o_alu_opr_1(o_alu_opr_1), .o_alu_opr_2(o_alu_opr_2), .o_rs2_data(o_rs2_data),
    .i_gpr_di(i_gpr_di), .i_is_lt(i_is_lt), .i_is_ltu(i_is_ltu), .i_is_zero(i_is_zero),
    .o_halt(o_halt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb [$];
  logic [31:0] e;
  logic [31:0] m_pc;
  logic [31:0] f_pc, x_opr1, x_opr2, x_rs2, n_pc;
  logic [7:0]  f_alu, f_mem, x_alu, x_mem;
  logic        x_load, x_store, n_halt;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // One FETCH+EXEC pair; enters and leaves 1ns after a rising edge
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] di,
                           input logic lt, input logic ltu, input logic zero);
    i_imem_data = instr;
    i_gpr_di = 32'd0;
    @(negedge clk);
    f_pc = o_imem_addr; f_alu = o_alu_op; f_mem = o_mem_op;
    @(posedge clk); #1;
    i_gpr_di = di; i_is_lt = lt; i_is_ltu = ltu; i_is_zero = zero;
    @(negedge clk);
    x_alu = o_alu_op; x_mem = o_mem_op; x_load = o_load; x_store = o_store;
    x_opr1 = o_alu_opr_1; x_opr2 = o_alu_opr_2; x_rs2 = o_rs2_data;
    @(posedge clk); #1;
    i_imem_data = NOP; i_is_lt = 1'b1; i_is_ltu = 1'b1; i_is_zero = 1'b1;
    n_pc = o_imem_addr; n_halt = o_halt;
  endtask

  task automatic set_reg(input logic [4:0] rd, input logic [31:0] val);
    run_instr(enc_i(12'h000, 5'd0, 3'b000, rd, 7'b0010011), val, 1'b1, 1'b1, 1'b1);
    m_pc = m_pc + 32'd4;
  endtask

  task automatic read_reg(input logic [4:0] rs, output logic [31:0] val);
    run_instr(enc_r(7'd0, 5'd0, rs, 3'b000, 5'd0), 32'h0, 1'b1, 1'b1, 1'b1);
    val = x_opr1;
    m_pc = m_pc + 32'd4;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_pc = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] obs [8];
    i_imem_data = NOP; i_gpr_di = 0; i_is_lt = 1; i_is_ltu = 1; i_is_zero = 1;
    rst_n = 1'b0;
    #2;
    obs = '{o_imem_addr, {31'd0, o_halt}, {24'd0, o_alu_op}, {24'd0, o_mem_op},
            {31'd0, o_load}, {31'd0, o_store}, o_alu_opr_1, o_alu_opr_2};
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'hFB); sb.push_back(32'hFF);
    sb.push_back(32'h1); sb.push_back(32'h1); sb.push_back(32'h0); sb.push_back(32'h0);
    for (int k = 0; k < 8; k++) begin
      e = sb.pop_front(); checks++;
      if (obs[k] !== e) begin failures++; $display("FAIL reset_out%0d got=%h exp=%h", k, obs[k], e); end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    m_pc = 32'h0;
  endtask

  task automatic test_addi();
    logic [31:0] v;
    sb.push_back(32'h0); sb.push_back(32'hFB); sb.push_back(32'hFF);
    sb.push_back(32'hFB); sb.push_back(32'h0); sb.push_back(32'h5); sb.push_back(32'h4);
    run_instr(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd5, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (f_pc !== e) begin failures++; $display("FAIL addi_fetch_pc got=%h exp=%h", f_pc, e); end
    e = sb.pop_front(); checks++;
    if (f_alu !== e[7:0]) begin failures++; $display("FAIL fetch_idle_alu got=%h exp=%h", f_alu, e[7:0]); end
    e = sb.pop_front(); checks++;
    if (f_mem !== e[7:0]) begin failures++; $display("FAIL fetch_idle_mem got=%h exp=%h", f_mem, e[7:0]); end
    e = sb.pop_front(); checks++;
    if (x_alu !== e[7:0]) begin failures++; $display("FAIL addi_alu_op got=%h exp=%h", x_alu, e[7:0]); end
    e = sb.pop_front(); checks++;
    if (x_opr1 !== e) begin failures++; $display("FAIL addi_opr1 got=%h exp=%h", x_opr1, e); end
    e = sb.pop_front(); checks++;
    if (x_opr2 !== e) begin failures++; $display("FAIL addi_opr2 got=%h exp=%h", x_opr2, e); end
    e = sb.pop_front(); checks++;
    if (n_pc !== e) begin failures++; $display("FAIL addi_next_pc got=%h exp=%h", n_pc, e); end
    sb.push_back(32'd5);
    read_reg(5'd1, v);
    e = sb.pop_front(); checks++;
    if (v !== e) begin failures++; $display("FAIL addi_x1 got=%h exp=%h", v, e); end
  endtask

  task automatic test_x0();
    sb.push_back(32'h0); sb.push_back(32'h0);
    run_instr(enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'd7, 1, 1, 1);
    run_instr(enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd4), 32'd0, 1, 1, 1);
    m_pc = m_pc + 8;
    e = sb.pop_front(); checks++;
    if (x_opr1 !== e) begin failures++; $display("FAIL x0_opr1 got=%h exp=%h", x_opr1, e); end
    e = sb.pop_front(); checks++;
    if (x_opr2 !== e) begin failures++; $display("FAIL x0_opr2 got=%h exp=%h", x_opr2, e); end
  endtask

  task automatic test_alu_ops();
    logic [17:0] tbl [10];
    tbl = '{{7'h00, 3'd0, 8'hFB}, {7'h20, 3'd0, 8'hFA}, {7'h00, 3'd1, 8'hDB},
            {7'h00, 3'd2, 8'h7A}, {7'h00, 3'd3, 8'hBA}, {7'h00, 3'd4, 8'hFC},
            {7'h00, 3'd5, 8'hEB}, {7'h20, 3'd5, 8'hF3}, {7'h00, 3'd6, 8'hFD},
            {7'h00, 3'd7, 8'hFE}};
    for (int k = 0; k < 10; k++) begin
      sb.push_back({24'd0, tbl[k][7:0]});
      run_instr(enc_r(tbl[k][17:11], 5'd1, 5'd1, tbl[k][10:8], 5'd0), 32'd0, 1, 1, 1);
      m_pc = m_pc + 4;
      e = sb.pop_front(); checks++;
      if (x_alu !== e[7:0]) begin failures++; $display("FAIL rtype%0d_alu got=%h exp=%h", k, x_alu, e[7:0]); end
    end
    sb.push_back(32'hF3); sb.push_back(32'd3);
    run_instr(enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd0, 7'b0010011), 32'd0, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (x_alu !== e[7:0]) begin failures++; $display("FAIL srai_alu got=%h exp=%h", x_alu, e[7:0]); end
    e = sb.pop_front(); checks++;
    if (x_opr2 !== e) begin failures++; $display("FAIL srai_shamt got=%h exp=%h", x_opr2, e); end
    sb.push_back(32'h7A); sb.push_back(32'hFFFF_FFFF);
    run_instr(enc_i(12'hFFF, 5'd1, 3'b010, 5'd0, 7'b0010011), 32'd0, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (x_alu !== e[7:0]) begin failures++; $display("FAIL slti_alu got=%h exp=%h", x_alu, e[7:0]); end
    e = sb.pop_front(); checks++;
    if (x_opr2 !== e) begin failures++; $display("FAIL slti_imm got=%h exp=%h", x_opr2, e); end
    sb.push_back(32'h0); sb.push_back(32'h1234_5000);
    run_instr({20'h12345, 5'd9, 7'b0110111}, 32'h1234_5000, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (x_opr1 !== e) begin failures++; $display("FAIL lui_opr1 got=%h exp=%h", x_opr1, e); end
    e = sb.pop_front(); checks++;
    if (x_opr2 !== e) begin failures++; $display("FAIL lui_opr2 got=%h exp=%h", x_opr2, e); end
    sb.push_back(m_pc); sb.push_back(32'h0000_1000);
    run_instr({20'h00001, 5'd9, 7'b0010111}, 32'h0, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (x_opr1 !== e) begin failures++; $display("FAIL auipc_opr1 got=%h exp=%h", x_opr1, e); end
    e = sb.pop_front(); checks++;
    if (x_opr2 !== e) begin failures++; $display("FAIL auipc_opr2 got=%h exp=%h", x_opr2, e); end
  endtask

  task automatic test_store_load();
    logic [31:0] v;
    do_reset();
    set_reg(5'd2, 32'h0000_0200);
    set_reg(5'd3, 32'hCAFE_F00D);
    sb.push_back(32'h0); sb.push_back(32'hFE); sb.push_back(32'h1);
    sb.push_back(32'hCAFE_F00D); sb.push_back(32'h4); sb.push_back(32'h200);
    run_instr(enc_s(12'd4, 5'd3, 5'd2, 3'b010), 32'hDEAD_BEEF, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (x_store !== e[0]) begin failures++; $display("FAIL sw_store got=%b exp=%b", x_store, e[0]); end
    e = sb.pop_front(); checks++;
    if (x_mem !== e[7:0]) begin failures++; $display("FAIL sw_mem_op got=%h exp=%h", x_mem, e[7:0]); end
    e = sb.pop_front(); checks++;
    if (x_load !== e[0]) begin failures++; $display("FAIL sw_load got=%b exp=%b", x_load, e[0]); end
    e = sb.pop_front(); checks++;
    if (x_rs2 !== e) begin failures++; $display("FAIL sw_rs2_data got=%h exp=%h", x_rs2, e); end
    e = sb.pop_front(); checks++;
    if (x_opr2 !== e) begin failures++; $display("FAIL sw_opr2 got=%h exp=%h", x_opr2, e); end
    e = sb.pop_front(); checks++;
    if (x_opr1 !== e) begin failures++; $display("FAIL sw_opr1 got=%h exp=%h", x_opr1, e); end
    sb.push_back(32'h0);
    read_reg(5'd4, v);
    e = sb.pop_front(); checks++;
    if (v !== e) begin failures++; $display("FAIL sw_no_write got=%h exp=%h", v, e); end
    sb.push_back(32'h0); sb.push_back(32'hDF); sb.push_back(32'h1);
    run_instr(enc_i(12'd0, 5'd2, 3'b010, 5'd6, 7'b0000011), 32'h0000_1234, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (x_load !== e[0]) begin failures++; $display("FAIL lw_load got=%b exp=%b", x_load, e[0]); end
    e = sb.pop_front(); checks++;
    if (x_mem !== e[7:0]) begin failures++; $display("FAIL lw_mem_op got=%h exp=%h", x_mem, e[7:0]); end
    e = sb.pop_front(); checks++;
    if (x_store !== e[0]) begin failures++; $display("FAIL lw_store got=%b exp=%b", x_store, e[0]); end
    sb.push_back(32'h0000_1234);
    read_reg(5'd6, v);
    e = sb.pop_front(); checks++;
    if (v !== e) begin failures++; $display("FAIL lw_x6 got=%h exp=%h", v, e); end
    sb.push_back(32'hEF);
    run_instr(enc_i(12'd1, 5'd2, 3'b100, 5'd7, 7'b0000011), 32'h0, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (x_mem !== e[7:0]) begin failures++; $display("FAIL lbu_mem_op got=%h exp=%h", x_mem, e[7:0]); end
    sb.push_back(32'hFB);
    run_instr(enc_s(12'd0, 5'd3, 5'd2, 3'b000), 32'h0, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (x_mem !== e[7:0]) begin failures++; $display("FAIL sb_mem_op got=%h exp=%h", x_mem, e[7:0]); end
  endtask

  task automatic test_branch();
    logic [2:0]  f3;
    logic        flag, taken, zr, lt, ltu;
    logic [31:0] exp_pc;
    do_reset();
    repeat (4) begin
      run_instr(NOP, 32'h0, 1, 1, 1);
      m_pc = m_pc + 4;
    end
    for (int i = 0; i < 6; i++) begin
      for (int v = 0; v < 2; v++) begin
        f3 = (i < 2) ? 3'(i) : 3'(i + 2);
        flag = v[0];
        taken = f3[0] ? flag : !flag;
        zr  = (f3[2:1] == 2'b00) ? flag : !flag;
        lt  = (f3[2:1] == 2'b10) ? flag : !flag;
        ltu = (f3[2:1] == 2'b11) ? flag : !flag;
        exp_pc = taken ? m_pc + 32'd8 : m_pc + 32'd4;
        sb.push_back(32'hFA); sb.push_back(exp_pc);
        run_instr(enc_b(13'd8, 5'd0, 5'd0, f3), 32'h0, lt, ltu, zr);
        e = sb.pop_front(); checks++;
        if (x_alu !== e[7:0]) begin failures++; $display("FAIL br_f3%0d_f%0d_alu got=%h exp=%h", f3, v, x_alu, e[7:0]); end
        e = sb.pop_front(); checks++;
        if (n_pc !== e) begin failures++; $display("FAIL br_f3%0d_f%0d_pc got=%h exp=%h", f3, v, n_pc, e); end
        m_pc = exp_pc;
      end
    end
    sb.push_back(m_pc - 32'd12);
    run_instr(enc_b(13'h1FF4, 5'd0, 5'd0, 3'b000), 32'h0, 1, 1, 0);
    e = sb.pop_front(); checks++;
    if (n_pc !== e) begin failures++; $display("FAIL br_backward_pc got=%h exp=%h", n_pc, e); end
    m_pc = m_pc - 32'd12;
    sb.push_back(32'h1); sb.push_back(m_pc);
    run_instr(enc_b(13'd6, 5'd0, 5'd0, 3'b000), 32'h0, 1, 1, 0);
    e = sb.pop_front(); checks++;
    if (n_halt !== e[0]) begin failures++; $display("FAIL br_misalign_halt got=%b exp=%b", n_halt, e[0]); end
    e = sb.pop_front(); checks++;
    if (n_pc !== e) begin failures++; $display("FAIL br_misalign_pc got=%h exp=%h", n_pc, e); end
  endtask

  task automatic test_jalr();
    logic [31:0] v;
    do_reset();
    set_reg(5'd2, 32'h0000_0101);
    sb.push_back(m_pc); sb.push_back(32'd4); sb.push_back(32'hFB); sb.push_back(32'h100);
    run_instr(enc_i(12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111), m_pc + 32'd4, 1, 1, 1);
    e = sb.pop_front(); checks++;
    if (x_opr1 !== e) begin failures++; $display("FAIL jalr_opr1 got=%h exp=%h", x_opr1, e); end
    e = sb.pop_front(); checks++;
    if (x_opr2 !== e) begin failures++; $display("FAIL jalr_opr2 got=%h exp=%h", x_opr2, e); end
    e = sb.pop_front(); checks++;
    if (x_alu !== e[7:0]) begin failures++; $display("FAIL jalr_alu got=%h exp=%h", x_alu, e[7:0]); end
    e = sb.pop_front(); checks++;
    if (n_pc !== e) begin failures++; $display("FAIL jalr_pc got=%h exp=%h", n_pc, e); end
    sb.push_back(m_pc + 32'd4);
    m_pc = 32'h100;
    read_reg(5'd1, v);
    e = sb.pop_front(); checks++;
    if (v !== e) begin failures++; $display("FAIL jalr_link got=%h exp=%h", v, e); end
    sb.push_back(m_pc + 32'd16);
    run_instr(enc_j(21'd16, 5'd5), m_pc + 32'd4, 1, 1, 1);
    e = sb.pop_front(); checks++;
    if (n_pc !== e) begin failures++; $display("FAIL jal_pc got=%h exp=%h", n_pc, e); end
    sb.push_back(m_pc + 32'd4);
    m_pc = m_pc + 32'd16;
    read_reg(5'd5, v);
    e = sb.pop_front(); checks++;
    if (v !== e) begin failures++; $display("FAIL jal_link got=%h exp=%h", v, e); end
    set_reg(5'd2, 32'h0000_0102);
    sb.push_back(32'h1); sb.push_back(m_pc); sb.push_back(32'h1); sb.push_back(m_pc);
    run_instr(enc_i(12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111), m_pc + 32'd4, 1, 1, 1);
    e = sb.pop_front(); checks++;
    if (n_halt !== e[0]) begin failures++; $display("FAIL jalr_misalign_halt got=%b exp=%b", n_halt, e[0]); end
    e = sb.pop_front(); checks++;
    if (n_pc !== e) begin failures++; $display("FAIL jalr_misalign_pc got=%h exp=%h", n_pc, e); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (o_halt !== e[0]) begin failures++; $display("FAIL halt_sticky got=%b exp=%b", o_halt, e[0]); end
    e = sb.pop_front(); checks++;
    if (o_imem_addr !== e) begin failures++; $display("FAIL halt_pc_hold got=%h exp=%h", o_imem_addr, e); end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    do_reset();
`ifdef FRONTEND_HALT_ON_ILLEGAL_EN
    sb.push_back(32'h1); sb.push_back(32'h0);
    run_instr(32'hFFFF_FFFF, 32'h55, 1, 1, 1);
    e = sb.pop_front(); checks++;
    if (n_halt !== e[0]) begin failures++; $display("FAIL illegal_halt got=%b exp=%b", n_halt, e[0]); end
    e = sb.pop_front(); checks++;
    if (n_pc !== e) begin failures++; $display("FAIL illegal_pc got=%h exp=%h", n_pc, e); end
`else
    sb.push_back(32'h0); sb.push_back(32'h4);
    run_instr(32'hFFFF_FFFF, 32'h55, 1, 1, 1);
    m_pc = m_pc + 4;
    e = sb.pop_front(); checks++;
    if (n_halt !== e[0]) begin failures++; $display("FAIL illegal_halt got=%b exp=%b", n_halt, e[0]); end
    e = sb.pop_front(); checks++;
    if (n_pc !== e) begin failures++; $display("FAIL illegal_pc got=%h exp=%h", n_pc, e); end
    sb.push_back(32'h0);
    read_reg(5'd31, v);
    e = sb.pop_front(); checks++;
    if (v !== e) begin failures++; $display("FAIL illegal_no_write got=%h exp=%h", v, e); end
`endif
  endtask

  task automatic test_ecall();
    do_reset();
    set_reg(5'd1, 32'h1);
    sb.push_back(32'h1); sb.push_back(m_pc); sb.push_back(32'hFB); sb.push_back(32'hFF);
    run_instr(32'h0000_0073, 32'h0, 1, 1, 1);
    e = sb.pop_front(); checks++;
    if (n_halt !== e[0]) begin failures++; $display("FAIL ecall_halt got=%b exp=%b", n_halt, e[0]); end
    e = sb.pop_front(); checks++;
    if (n_pc !== e) begin failures++; $display("FAIL ecall_pc got=%h exp=%h", n_pc, e); end
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (o_alu_op !== e[7:0]) begin failures++; $display("FAIL halt_idle_alu got=%h exp=%h", o_alu_op, e[7:0]); end
    e = sb.pop_front(); checks++;
    if (o_mem_op !== e[7:0]) begin failures++; $display("FAIL halt_idle_mem got=%h exp=%h", o_mem_op, e[7:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] v;
    do_reset();
    set_reg(5'd7, 32'h77);
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    i_imem_data = enc_i(12'd9, 5'd0, 3'b000, 5'd7, 7'b0010011);
    @(posedge clk); #1;
    i_gpr_di = 32'd9;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    e = sb.pop_front(); checks++;
    if (o_imem_addr !== e) begin failures++; $display("FAIL midrst_pc got=%h exp=%h", o_imem_addr, e); end
    e = sb.pop_front(); checks++;
    if (o_halt !== e[0]) begin failures++; $display("FAIL midrst_halt got=%b exp=%b", o_halt, e[0]); end
    @(posedge clk); #1 rst_n = 1'b1;
    i_imem_data = NOP; i_gpr_di = 32'd0;
    m_pc = 32'h0;
    read_reg(5'd7, v);
    e = sb.pop_front(); checks++;
    if (f_pc !== e) begin failures++; $display("FAIL midrst_refetch got=%h exp=%h", f_pc, e); end
    e = sb.pop_front(); checks++;
    if (v !== e) begin failures++; $display("FAIL midrst_x7 got=%h exp=%h", v, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_addi();
    test_x0();
    test_alu_ops();
    test_store_load();
    test_branch();
    test_jalr();
    test_illegal();
    test_ecall();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
